// File: rtl/calculator_alu_seq_pkg.sv
// Shared types, key codes and keypad decode for the sequential calculator core.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    RESULT  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

  localparam logic [4:0] KEY_PLUS  = 5'd3;
  localparam logic [4:0] KEY_MINUS = 5'd7;
  localparam logic [4:0] KEY_EQUAL = 5'd11;
  localparam logic [4:0] KEY_CLEAR = 5'd15;
  localparam logic [4:0] KEY_ZERO  = 5'd13;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } digit_t;

  // Keypad is a 4x4 grid with the right column holding operators.
  function automatic digit_t key_to_digit(input logic [4:0] code);
    digit_t d;
    d.vld = 1'b1;
    d.val = 4'd0;
    case (code)
      5'd0, 5'd1, 5'd2:  d.val = 4'(code + 5'd1);
      5'd4, 5'd5, 5'd6:  d.val = 4'(code);
      5'd8, 5'd9, 5'd10: d.val = 4'(code - 5'd1);
      KEY_ZERO:          d.val = 4'd0;
      default:           d.vld = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calculator_alu_seq_if.sv
// Keypad-in / display-out bundle between the scanner, the calculator core and the display.
interface calculator_alu_seq_if #(
  parameter int WIDTH = 10
) ();
  logic             key_flag;
  logic [4:0]       key_code;
  logic [WIDTH-1:0] display_value;
  logic             display_neg;
  logic             error;
  logic             key_event;
  logic [1:0]       state_o;

  modport master (
    output key_flag, key_code,
    input  display_value, display_neg, error, key_event, state_o
  );

  modport slave (
    input  key_flag, key_code,
    output display_value, display_neg, error, key_event, state_o
  );
endinterface

// File: rtl/calculator_alu_seq_sampler.sv
// Prescaled keypad sampler: one press pulse per rising edge of key_flag seen on strobes.
module key_event_sampler #(
  parameter int SAMPLE_LOG2 = 10
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       i_key_flag,
  input  logic [4:0] i_key_code,
  output logic       o_press,
  output logic [4:0] o_code
);

  logic [SAMPLE_LOG2-1:0] r_presc;
  logic                   r_prev_flag;
  logic                   w_strobe;

  assign w_strobe = &r_presc;
  // Press is combinational on the strobe cycle so the core's registered outputs land one cycle later.
  assign o_press  = w_strobe & i_key_flag & ~r_prev_flag;
  assign o_code   = i_key_code;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_prev_flag <= 1'b0;
    end else begin
      r_presc <= r_presc + SAMPLE_LOG2'(1);
      if (w_strobe) r_prev_flag <= i_key_flag;
    end
  end

endmodule

// File: rtl/calculator_alu_seq.sv
// Keypad calculator core: multi-digit entry, chained add/subtract, signed result, overflow lock.
module calculator_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int MAX_DIGITS  = 3,
  parameter int SAMPLE_LOG2 = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  calculator_alu_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);
  localparam logic [WIDTH+1:0] MAXV = {2'b00, {WIDTH{1'b1}}};

  logic             w_press;
  logic [4:0]       w_code;
  digit_t           w_dig;
  logic             w_addsub;
  op_t              w_newop;
  logic signed [WIDTH+1:0] w_res;
  logic [WIDTH+1:0] w_mag;
  logic             w_ovf;

  state_t             r_state, n_state;
  op_t                r_op, n_op;
  logic [WIDTH-1:0]   r_entry, n_entry;
  logic signed [WIDTH:0] r_acc, n_acc;
  logic [CNT_W-1:0]   r_cnt, n_cnt;
  logic               r_err, n_err;
  logic [WIDTH-1:0]   r_disp, n_disp;
  logic               r_neg, n_neg;
  logic               r_event;

  key_event_sampler #(.SAMPLE_LOG2(SAMPLE_LOG2)) u_sampler (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .i_key_flag(bus.key_flag),
    .i_key_code(bus.key_code),
    .o_press   (w_press),
    .o_code    (w_code)
  );

  // Pending operation evaluated with two guard bits so overflow is visible before truncation.
  always_comb begin
    w_res = (r_op == SUB) ? ($signed({r_acc[WIDTH], r_acc}) - $signed({2'b00, r_entry}))
                          : ($signed({r_acc[WIDTH], r_acc}) + $signed({2'b00, r_entry}));
    w_mag = w_res[WIDTH+1] ? 32'(-w_res) : w_res;
    w_ovf = w_mag > MAXV;
  end

  always_comb begin
    n_state  = r_state;
    n_op     = r_op;
    n_entry  = r_entry;
    n_acc    = r_acc;
    n_cnt    = r_cnt;
    n_err    = r_err;
    w_dig    = key_to_digit(w_code);
    w_addsub = (w_code == KEY_PLUS) || (w_code == KEY_MINUS);
    w_newop  = (w_code == KEY_MINUS) ? SUB : ADD;

    if (w_press) begin
      if (w_code == KEY_CLEAR) begin
        n_state = ENTRY_A;
        n_op    = ADD;
        n_entry = '0;
        n_acc   = '0;
        n_cnt   = '0;
        n_err   = 1'b0;
      end else if (r_state != ERROR) begin
        if (w_dig.vld) begin
          if (r_state == RESULT) begin
            n_entry = WIDTH'(w_dig.val);
            n_cnt   = CNT_W'(1);
            n_acc   = '0;
            n_state = ENTRY_A;
          end else if (r_cnt < CNT_W'(MAX_DIGITS)) begin
            n_entry = r_entry * TEN + WIDTH'(w_dig.val);
            n_cnt   = r_cnt + CNT_W'(1);
          end
        end else if (w_addsub) begin
          case (r_state)
            ENTRY_A: begin
              n_acc   = $signed({1'b0, r_entry});
              n_op    = w_newop;
              n_entry = '0;
              n_cnt   = '0;
              n_state = ENTRY_B;
            end
            ENTRY_B: begin
              if (w_ovf) begin
                n_state = ERROR;
                n_err   = 1'b1;
              end else begin
                n_acc   = w_res[WIDTH:0];
                n_op    = w_newop;
                n_entry = '0;
                n_cnt   = '0;
              end
            end
            default: begin
              n_op    = w_newop;
              n_entry = '0;
              n_cnt   = '0;
              n_state = ENTRY_B;
            end
          endcase
        end else if (w_code == KEY_EQUAL && r_state == ENTRY_B) begin
          if (w_ovf) begin
            n_state = ERROR;
            n_err   = 1'b1;
          end else begin
            n_acc   = w_res[WIDTH:0];
            n_entry = '0;
            n_cnt   = '0;
            n_state = RESULT;
          end
        end
      end
    end

    case (n_state)
      ERROR: begin
        n_disp = '1;
        n_neg  = 1'b0;
      end
      RESULT: begin
        n_disp = n_acc[WIDTH] ? WIDTH'(-n_acc) : WIDTH'(n_acc);
        n_neg  = n_acc[WIDTH];
      end
      default: begin
        n_disp = n_entry;
        n_neg  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTRY_A;
      r_op    <= ADD;
      r_entry <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_disp  <= '0;
      r_neg   <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_state <= n_state;
      r_op    <= n_op;
      r_entry <= n_entry;
      r_acc   <= n_acc;
      r_cnt   <= n_cnt;
      r_err   <= n_err;
      r_disp  <= n_disp;
      r_neg   <= n_neg;
      r_event <= w_press;
    end
  end

  assign bus.display_value = r_disp;
  assign bus.display_neg   = r_neg;
  assign bus.error         = r_err;
  assign bus.key_event     = r_event;
  assign bus.state_o       = r_state;

endmodule
